// File: rtl/fetch_pkg.sv
// Shared constants and the default prefetch entry layout for the fetch unit.
package fetch_pkg;

    localparam int unsigned DEF_ADDR_WIDTH  = 32;
    localparam int unsigned DEF_INSTR_WIDTH = 32;
    localparam int unsigned FETCH_STRIDE    = 4;

    // One buffered fetch result: where it came from, what came back, and
    // whether the bus flagged it.
    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0]  pc;
        logic [DEF_INSTR_WIDTH-1:0] instr;
        logic                       err;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO. The head entry is read straight from storage,
// so a pushed entry becomes visible the cycle after the push. Clear wins
// over push and pop; a push while full is only honoured together with a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_W   = $clog2(DEPTH + 1),
    parameter type         entry_t = fetch_entry_t
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  entry_t           wr_data,
    output entry_t           rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    // Qualify push/pop against the current occupancy.
    always_comb begin
        w_do_pop  = 1'b0;
        w_do_push = 1'b0;
        if (pop && (r_count != CNT_W'(0))) begin
            w_do_pop = 1'b1;
        end else begin
            w_do_pop = 1'b0;
        end
        if (push && ((r_count != CNT_W'(DEPTH)) || w_do_pop)) begin
            w_do_push = 1'b1;
        end else begin
            w_do_push = 1'b0;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_count  <= CNT_W'(0);
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents need no reset because the head is gated by empty.
    always_ff @(posedge clk) begin
        if (w_do_push && !rst && !clear) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign full    = (r_count == CNT_W'(DEPTH));
    assign empty   = (r_count == CNT_W'(0));
    assign count   = r_count;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch with a prefetch FIFO and several in-order outstanding
// imem requests. Stale responses after a redirect are discarded by counting
// how many requests were still in flight when the redirect hit.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned MAX_OUTST   = 2,
    parameter int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rst,
    input  logic [ADDR_WIDTH-1:0]  boot_addr,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    input  logic                   stall,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    input  logic                   imem_rsp_err,
    output logic                   if_valid,
    input  logic                   dec_ready,
    output logic [INSTR_WIDTH-1:0] instr_dec,
    output logic [ADDR_WIDTH-1:0]  pc_dec,
    output logic [ADDR_WIDTH-1:0]  pc_plus4_dec,
    output logic                   fetch_err_dec,
    output logic                   pc_misaligned,
    output logic [ADDR_WIDTH-1:0]  fault_pc,
    output logic [CNT_W-1:0]       buf_count
);

    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(FETCH_STRIDE);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
        logic                   err;
    } entry_t;

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_rsp_pc;
    logic [CNT_W-1:0]      r_outst;
    logic [CNT_W-1:0]      r_drop_cnt;

    entry_t                w_head;
    entry_t                w_push_entry;
    logic                  w_empty;
    logic                  w_full;
    logic [CNT_W-1:0]      w_count;
    logic [CNT_W:0]        w_credit_sum;
    logic                  w_misaligned;
    logic                  w_req_valid;
    logic                  w_req_fire;
    logic                  w_rsp_accept;
    logic                  w_rsp_drop;
    logic                  w_push;
    logic                  w_fifo_push;
    logic                  w_if_valid;
    logic                  w_pop;

    // Issue credit, response classification and FIFO handshakes.
    always_comb begin
        w_misaligned = (r_fetch_pc[1:0] != 2'b00);
        w_credit_sum = {1'b0, w_count} + {1'b0, r_outst};
        w_req_valid  = !cpu_rst && !redirect_valid && !stall && !w_misaligned
                       && (r_outst < CNT_W'(MAX_OUTST))
                       && (w_credit_sum < (CNT_W + 1)'(DEPTH));
        w_req_fire   = w_req_valid && imem_req_ready;
        // A response with nothing outstanding is a protocol error and is ignored.
        w_rsp_accept = !cpu_rst && imem_rsp_valid && (r_outst != CNT_W'(0));
        w_rsp_drop   = w_rsp_accept && (r_drop_cnt != CNT_W'(0));
        w_push       = w_rsp_accept && !w_rsp_drop && !redirect_valid;
        w_if_valid   = !w_empty && !stall;
        w_pop        = w_if_valid && dec_ready && !redirect_valid && !cpu_rst;
        w_fifo_push  = w_push && (!w_full || w_pop);
        w_push_entry = '{pc: r_rsp_pc, instr: imem_rsp_data, err: imem_rsp_err};
    end

    // PC, in-flight and stale-response counters; redirect overrides normal updates.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_fetch_pc <= boot_addr;
            r_rsp_pc   <= boot_addr;
            r_outst    <= CNT_W'(0);
            r_drop_cnt <= CNT_W'(0);
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_rsp_pc   <= redirect_pc;
            // Everything still in flight after this cycle is now stale.
            r_outst    <= r_outst - CNT_W'(w_rsp_accept);
            r_drop_cnt <= r_outst - CNT_W'(w_rsp_accept);
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + STRIDE;
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + STRIDE;
            end
            r_outst <= r_outst + CNT_W'(w_req_fire) - CNT_W'(w_rsp_accept);
            if (w_rsp_drop) begin
                r_drop_cnt <= r_drop_cnt - CNT_W'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (cpu_clk),
        .rst     (cpu_rst),
        .push    (w_fifo_push),
        .pop     (w_pop),
        .clear   (redirect_valid),
        .wr_data (w_push_entry),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    // Decode-side view of the FIFO head, zeroed while the FIFO is empty.
    always_comb begin
        instr_dec     = {INSTR_WIDTH{1'b0}};
        pc_dec        = {ADDR_WIDTH{1'b0}};
        pc_plus4_dec  = {ADDR_WIDTH{1'b0}};
        fetch_err_dec = 1'b0;
        if (!w_empty) begin
            instr_dec     = w_head.instr;
            pc_dec        = w_head.pc;
            pc_plus4_dec  = w_head.pc + STRIDE;
            fetch_err_dec = w_head.err;
        end else begin
            instr_dec     = {INSTR_WIDTH{1'b0}};
            pc_dec        = {ADDR_WIDTH{1'b0}};
            pc_plus4_dec  = {ADDR_WIDTH{1'b0}};
            fetch_err_dec = 1'b0;
        end
    end

    // Misalignment flag and the faulting PC it reports.
    always_comb begin
        pc_misaligned = w_misaligned;
        fault_pc      = {ADDR_WIDTH{1'b0}};
        if (w_misaligned) begin
            fault_pc = r_fetch_pc;
        end else begin
            fault_pc = {ADDR_WIDTH{1'b0}};
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign if_valid       = w_if_valid;
    assign buf_count      = w_count;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: an in-order imem model with
// programmable latency, a scoreboard of expected decode PCs, a cycle table
// for backpressure/misalignment, and hand sequences for redirect and stall.
module tb_fetch_prefetch_unit;

    logic        cpu_clk;
    logic        cpu_rst;
    logic [31:0] boot_addr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        if_valid;
    logic        dec_ready;
    logic [31:0] instr_dec;
    logic [31:0] pc_dec;
    logic [31:0] pc_plus4_dec;
    logic        fetch_err_dec;
    logic        pc_misaligned;
    logic [31:0] fault_pc;
    logic [2:0]  buf_count;

    fetch_prefetch_unit #(
        .ADDR_WIDTH  (32),
        .INSTR_WIDTH (32),
        .DEPTH       (4),
        .MAX_OUTST   (2)
    ) dut (
        .cpu_clk        (cpu_clk),
        .cpu_rst        (cpu_rst),
        .boot_addr      (boot_addr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .if_valid       (if_valid),
        .dec_ready      (dec_ready),
        .instr_dec      (instr_dec),
        .pc_dec         (pc_dec),
        .pc_plus4_dec   (pc_plus4_dec),
        .fetch_err_dec  (fetch_err_dec),
        .pc_misaligned  (pc_misaligned),
        .fault_pc       (fault_pc),
        .buf_count      (buf_count)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [31:0] addr;
        int          rdy;
    } mreq_t;

    typedef struct {
        bit          do_reset;
        logic [31:0] boot;
        bit          redir;
        logic [31:0] rpc;
        bit          stl;
        bit          rdy;
        bit          e_rv;
        logic [31:0] e_addr;
        bit          e_if;
        logic [2:0]  e_buf;
        bit          e_mis;
        logic [31:0] e_fault;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          lat   = 1;
    logic [31:0] err_addr = 32'h0000_1004;
    logic [31:0] exp_fetch;
    logic [31:0] sbq [$];
    mreq_t       mq  [$];
    vec_t        tbl [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive this cycle's imem response from the in-order memory model.
    task automatic set_rsp();
        mreq_t m;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        if (!cpu_rst && mq.size() > 0 && mq[0].rdy <= cyc) begin
            m = mq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~m.addr;
            imem_rsp_err   = (m.addr == err_addr);
        end
    endtask

    // Score the handshakes of the current cycle, then advance one clock.
    task automatic cycle();
        logic [31:0] e;
        #1;
        if (cpu_rst) begin
            sbq.delete();
            mq.delete();
            exp_fetch = boot_addr;
        end else if (redirect_valid) begin
            sbq.delete();
            exp_fetch = redirect_pc;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", {32'h0, imem_req_addr}, {32'h0, exp_fetch});
                sbq.push_back(exp_fetch);
                mq.push_back('{exp_fetch, cyc + lat});
                exp_fetch = exp_fetch + 32'd4;
            end
            if (if_valid && dec_ready) begin
                if (sbq.size() == 0) begin
                    check("sb_underflow_pc", {32'h0, pc_dec}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    check("dec_pc",    {32'h0, pc_dec},       {32'h0, e});
                    check("dec_instr", {32'h0, instr_dec},    {32'h0, ~e});
                    check("dec_plus4", {32'h0, pc_plus4_dec}, {32'h0, e + 32'd4});
                    check("dec_err",   {63'h0, fetch_err_dec}, {63'h0, (e == err_addr)});
                end
            end
        end
        @(posedge cpu_clk);
        cyc++;
        @(negedge cpu_clk);
        set_rsp();
    endtask

    task automatic do_reset(input logic [31:0] b);
        cpu_rst        = 1'b1;
        boot_addr      = b;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        cycle();
        cycle();
        #1;
        check("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        check("rst_req_addr",  {32'h0, imem_req_addr},  {32'h0, b});
        check("rst_if_valid",  {63'h0, if_valid},       64'h0);
        check("rst_buf_count", {61'h0, buf_count},      64'h0);
        check("rst_pc_dec",    {32'h0, pc_dec},         64'h0);
        cpu_rst = 1'b0;
    endtask

    initial begin
        cpu_rst        = 1'b1;
        boot_addr      = 32'h0000_1000;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        exp_fetch      = 32'h0;

        // cycle-table: {reset, boot, redir, rpc, stall, dec_ready | req_v, req_addr, if_v, buf, mis, fault}
        tbl.push_back('{1, 32'h1000, 0, 32'h0,    0, 0, 1, 32'h1000, 0, 3'd0, 0, 32'h0});
        tbl.push_back('{0, 32'h1000, 0, 32'h0,    0, 0, 1, 32'h1004, 0, 3'd0, 0, 32'h0});
        tbl.push_back('{0, 32'h1000, 0, 32'h0,    0, 0, 1, 32'h1008, 1, 3'd1, 0, 32'h0});
        tbl.push_back('{0, 32'h1000, 0, 32'h0,    0, 0, 1, 32'h100C, 1, 3'd2, 0, 32'h0});
        tbl.push_back('{0, 32'h1000, 0, 32'h0,    0, 0, 0, 32'h0,    1, 3'd3, 0, 32'h0});
        tbl.push_back('{0, 32'h1000, 0, 32'h0,    0, 0, 0, 32'h0,    1, 3'd4, 0, 32'h0});
        tbl.push_back('{0, 32'h1000, 0, 32'h0,    0, 0, 0, 32'h0,    1, 3'd4, 0, 32'h0});
        tbl.push_back('{0, 32'h1000, 0, 32'h0,    0, 1, 0, 32'h0,    1, 3'd4, 0, 32'h0});
        tbl.push_back('{0, 32'h1000, 0, 32'h0,    0, 1, 1, 32'h1010, 1, 3'd3, 0, 32'h0});
        tbl.push_back('{1, 32'h1000, 1, 32'h3002, 0, 1, 0, 32'h0,    0, 3'd0, 0, 32'h0});
        tbl.push_back('{0, 32'h1000, 0, 32'h0,    0, 1, 0, 32'h0,    0, 3'd0, 1, 32'h3002});
        tbl.push_back('{0, 32'h1000, 0, 32'h0,    0, 1, 0, 32'h0,    0, 3'd0, 1, 32'h3002});
        tbl.push_back('{0, 32'h1000, 0, 32'h0,    0, 1, 0, 32'h0,    0, 3'd0, 1, 32'h3002});
        tbl.push_back('{0, 32'h1000, 1, 32'h4000, 0, 1, 0, 32'h0,    0, 3'd0, 1, 32'h3002});
        tbl.push_back('{0, 32'h1000, 0, 32'h0,    0, 1, 1, 32'h4000, 0, 3'd0, 0, 32'h0});
        tbl.push_back('{0, 32'h1000, 0, 32'h0,    0, 1, 1, 32'h4004, 0, 3'd0, 0, 32'h0});
        tbl.push_back('{0, 32'h1000, 0, 32'h0,    0, 1, 1, 32'h4008, 1, 3'd1, 0, 32'h0});
        tbl.push_back('{0, 32'h1000, 0, 32'h0,    0, 1, 1, 32'h400C, 1, 3'd1, 0, 32'h0});

        @(negedge cpu_clk);
        set_rsp();

        // Basic streaming from boot, 1-cycle memory, error on 0x1004.
        lat = 1;
        dec_ready = 1'b1;
        do_reset(32'h0000_1000);
        #1;
        check("t1_c0_req_valid", {63'h0, imem_req_valid}, 64'h1);
        check("t1_c0_req_addr",  {32'h0, imem_req_addr},  64'h1000);
        check("t1_c0_if_valid",  {63'h0, if_valid},       64'h0);
        cycle();
        #1;
        check("t1_c1_if_valid",  {63'h0, if_valid},       64'h0);
        cycle();
        #1;
        check("t1_c2_if_valid",  {63'h0, if_valid},       64'h1);
        check("t1_c2_pc_dec",    {32'h0, pc_dec},         64'h1000);
        check("t1_c2_plus4",     {32'h0, pc_plus4_dec},   64'h1004);
        check("t1_c2_err",       {63'h0, fetch_err_dec},  64'h0);
        cycle();
        #1;
        check("t1_c3_pc_dec",    {32'h0, pc_dec},         64'h1004);
        check("t1_c3_err",       {63'h0, fetch_err_dec},  64'h1);
        repeat (8) cycle();

        // Cycle table: backpressure credit limit, then misalignment.
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].do_reset) begin
                dec_ready = tbl[i].rdy;
                do_reset(tbl[i].boot);
            end
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            stall          = tbl[i].stl;
            dec_ready      = tbl[i].rdy;
            #1;
            check($sformatf("tbl%0d_req_valid", i), {63'h0, imem_req_valid}, {63'h0, tbl[i].e_rv});
            if (tbl[i].e_rv) begin
                check($sformatf("tbl%0d_req_addr", i), {32'h0, imem_req_addr}, {32'h0, tbl[i].e_addr});
            end
            check($sformatf("tbl%0d_if_valid", i),  {63'h0, if_valid},      {63'h0, tbl[i].e_if});
            check($sformatf("tbl%0d_buf_count", i), {61'h0, buf_count},     {61'h0, tbl[i].e_buf});
            check($sformatf("tbl%0d_misalign", i),  {63'h0, pc_misaligned}, {63'h0, tbl[i].e_mis});
            check($sformatf("tbl%0d_fault_pc", i),  {32'h0, fault_pc},      {32'h0, tbl[i].e_fault});
            cycle();
        end
        redirect_valid = 1'b0;
        stall          = 1'b0;
        dec_ready      = 1'b1;
        repeat (6) cycle();

        // Redirect coinciding with the first of two in-flight responses.
        lat = 2;
        do_reset(32'h0000_2000);
        cycle();
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        #1;
        check("t3_redirect_req_valid", {63'h0, imem_req_valid}, 64'h0);
        cycle();
        redirect_valid = 1'b0;
        cycle();
        #1;
        check("t3_drop_buf_count", {61'h0, buf_count}, 64'h0);
        check("t3_drop_if_valid",  {63'h0, if_valid},  64'h0);
        cycle();
        cycle();
        #1;
        check("t3_first_if_valid", {63'h0, if_valid}, 64'h1);
        check("t3_first_pc_dec",   {32'h0, pc_dec},   64'h3000);
        repeat (8) cycle();

        // Stall with responses pending, then drain completely.
        lat = 3;
        do_reset(32'h0000_5000);
        repeat (8) cycle();
        stall = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1;
            check("stall_if_valid",  {63'h0, if_valid},       64'h0);
            check("stall_req_valid", {63'h0, imem_req_valid}, 64'h0);
            check("stall_buf_le_depth", {63'h0, (buf_count <= 3'd4)}, 64'h1);
            cycle();
        end
        stall = 1'b0;
        repeat (12) cycle();
        imem_req_ready = 1'b0;
        repeat (10) cycle();
        #1;
        check("drain_buf_count", {61'h0, buf_count}, 64'h0);
        check("drain_sb_left",   {32'h0, 32'(sbq.size())}, 64'h0);
        imem_req_ready = 1'b1;

        // Address wrap past the top of the address space.
        lat = 1;
        do_reset(32'hFFFF_FFF8);
        repeat (8) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
